// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one signed N x N multiplier between two requesters.
// Accept -> one compute cycle -> response held until consumed.
module mult_rr_sched #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_op1,
    input  logic [N-1:0]   req0_op2,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_op1,
    input  logic [N-1:0]   req1_op2,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [2*N-1:0] resp_out
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t                state, state_nxt;
    logic signed [N-1:0]   op1_q, op2_q;
    logic signed [2*N-1:0] product;
    logic                  cur_id;
    logic                  last_grant;
    logic                  gnt;
    logic                  any_req;

    always_comb begin
        any_req = req0_valid | req1_valid;
        gnt     = 1'b0;
        if (req0_valid && req1_valid)
            gnt = ~last_grant;
        else if (req1_valid)
            gnt = 1'b1;
    end

    assign req0_ready = (state == IDLE) & req0_valid & ~gnt;
    assign req1_ready = (state == IDLE) & req1_valid & gnt;

    // Sign-extend to the product width before multiplying so nothing is truncated.
    assign product = (2*N)'(op1_q) * (2*N)'(op2_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op1_q      <= '0;
            op2_q      <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_out   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op1_q      <= gnt ? req1_op1 : req0_op1;
                        op2_q      <= gnt ? req1_op2 : req0_op2;
                        cur_id     <= gnt;
                        last_grant <= gnt;
                    end
                end
                CALC: begin
                    resp_out   <= product;
                    resp_id    <= cur_id;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready)
                        resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Self-checking bench for mult_rr_sched: vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mult_rr_sched;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req0_ready;
    logic [N-1:0]   req0_op1, req0_op2;
    logic           req1_valid, req1_ready;
    logic [N-1:0]   req1_op1, req1_op2;
    logic           resp_valid, resp_ready, resp_id;
    logic [2*N-1:0] resp_out;

    int checks   = 0;
    int failures = 0;

    mult_rr_sched #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_out   (resp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[7:0];
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic reset_dut();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic single(input vec_t v, input string name);
        resp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1; req1_op1 = v.a; req1_op2 = v.b;
        end else begin
            req0_valid = 1'b1; req0_op1 = v.a; req0_op2 = v.b;
        end
        #1;
        chk({name, " ready"}, {30'd0, req1_ready, req0_ready}, v.id ? 32'd2 : 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({name, " calc valid"}, resp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({name, " resp valid"}, resp_valid, 1);
        chk({name, " resp id"}, resp_id, v.id);
        chk({name, " resp out"}, resp_out, v.exp);
        @(posedge clk);
        @(negedge clk);
        chk({name, " done"}, resp_valid, 0);
    endtask

    initial begin
        logic       busy, last, pend_id, g, exp_rv;
        logic [7:0] pend_out;
        int         cyc;
        logic       drop0, drop1;

        vecs[0] = '{1'b0, 4'd3, 4'hE, 8'hFA};
        vecs[1] = '{1'b0, 4'h8, 4'h8, 8'h40};
        vecs[2] = '{1'b1, 4'h8, 4'h7, 8'hC8};
        vecs[3] = '{1'b1, 4'h7, 4'h7, 8'h31};
        vecs[4] = '{1'b0, 4'h0, 4'hB, 8'h00};
        vecs[5] = '{1'b1, 4'hF, 4'hF, 8'h01};

        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_op1 = '0; req0_op2 = '0; req1_op1 = '0; req1_op2 = '0;
        @(negedge clk);
        reset_dut();
        #1;
        chk("reset valid", resp_valid, 0);
        chk("reset id", resp_id, 0);
        chk("reset out", resp_out, 0);
        chk("reset ready", {req1_ready, req0_ready}, 0);

        foreach (vecs[i]) single(vecs[i], $sformatf("vec%0d", i));

        // Both continuously valid: strict alternation, one op per three cycles.
        reset_dut();
        req0_valid = 1'b1; req0_op1 = 4'd2; req0_op2 = 4'd3;
        req1_valid = 1'b1; req1_op1 = 4'hF; req1_op2 = 4'd5;
        resp_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            #1;
            if (k % 3 == 0)
                chk($sformatf("rr ready k%0d", k), {req1_ready, req0_ready},
                    ((k / 3) % 2 == 1) ? 32'd2 : 32'd1);
            else
                chk($sformatf("rr busy ready k%0d", k), {req1_ready, req0_ready}, 0);
            chk($sformatf("rr valid k%0d", k), resp_valid, (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k % 3 == 2) begin
                chk($sformatf("rr id k%0d", k), resp_id, (k / 3) % 2);
                chk($sformatf("rr out k%0d", k), resp_out,
                    ((k / 3) % 2 == 1) ? 32'hFB : 32'h06);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Backpressure: response held five cycles while req1 waits.
        reset_dut();
        req0_valid = 1'b1; req0_op1 = 4'd5; req0_op2 = 4'hD;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op1 = 4'd1; req1_op2 = 4'd1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp valid", resp_valid, 1);
            chk("bp id", resp_id, 0);
            chk("bp out", resp_out, 8'hF1);
            chk("bp ready", {req1_ready, req0_ready}, 0);
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("bp release valid", resp_valid, 0);
        chk("bp release ready", {req1_ready, req0_ready}, 2);
        req1_valid = 1'b0;

        // Reset in CALC, then in RESP.
        reset_dut();
        req1_valid = 1'b1; req1_op1 = 4'd3; req1_op2 = 4'd3;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst calc valid", resp_valid, 0);
        req0_valid = 1'b1; req0_op1 = 4'd2; req0_op2 = 4'd2;
        req1_valid = 1'b1;
        #1;
        chk("rst calc tie", {req1_ready, req0_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre-rst resp valid", resp_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst resp valid", resp_valid, 0);
        chk("rst resp out", resp_out, 0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("no stale resp", resp_valid, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst resp tie", {req1_ready, req0_ready}, 1);

        // Randomized traffic against a transaction-level model.
        reset_dut();
        busy = 1'b0; last = 1'b1; cyc = 0; pend_id = 1'b0; pend_out = '0;
        drop0 = 1'b0; drop1 = 1'b0;
        for (int t = 0; t < 600; t++) begin
            if (drop0) req0_valid = 1'b0;
            if (drop1) req1_valid = 1'b0;
            drop0 = 1'b0; drop1 = 1'b0;
            if (!req0_valid && $urandom_range(0, 2) != 0) begin
                req0_valid = 1'b1; req0_op1 = 4'($urandom); req0_op2 = 4'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) != 0) begin
                req1_valid = 1'b1; req1_op1 = 4'($urandom); req1_op2 = 4'($urandom);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = (req0_valid && req1_valid) ? ~last : req1_valid;
            chk("rnd ready0", req0_ready, !busy && req0_valid && !g);
            chk("rnd ready1", req1_ready, !busy && req1_valid && g);
            exp_rv = busy && cyc >= 1;
            chk("rnd resp valid", resp_valid, exp_rv);
            if (exp_rv) begin
                chk("rnd resp id", resp_id, pend_id);
                chk("rnd resp out", resp_out, pend_out);
            end
            if (busy) begin
                if (cyc >= 1 && resp_ready) busy = 1'b0;
                else cyc++;
            end else if (req0_valid || req1_valid) begin
                busy = 1'b1; cyc = 0; pend_id = g; last = g;
                pend_out = g ? ref_mul(req1_op1, req1_op2) : ref_mul(req0_op1, req0_op2);
                if (g) drop1 = 1'b1; else drop0 = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
